// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register issue/writeback scoreboard; R0 reads as zero.
// Define RF_BYPASS_EN to forward same-edge writeback data and pending state to the read ports.
module regfile_mp_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     busy_any
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pendNext;
  logic              wrLive;
  logic              busyQ;

  assign wrLive = wr_en && (wr_addr != '0);

  // Issue sets, writeback clears, set wins on collision; R0 never pending.
  always_comb begin
    pendNext = pend;
    for (int unsigned a = 1; a < DEPTH; a++) begin
      if (iss_en && (iss_addr == ADDR_W'(a))) begin
        pendNext[ADDR_W'(a)] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(a))) begin
        pendNext[ADDR_W'(a)] = 1'b0;
      end
    end
    pendNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        regs[ADDR_W'(a)] <= '0;
      end
      pend  <= '0;
      busyQ <= 1'b0;
    end else begin
      if (wrLive) begin
        regs[wr_addr] <= wr_data;
      end
      pend  <= pendNext;
      busyQ <= |pendNext;
    end
  end

  assign busy_any = busyQ;

  for (genvar g = 0; g < NUM_RD; g++) begin : gPort
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataD;
    logic [DATA_W-1:0] dataQ;
    logic              pendD;
    logic              pendQ;
    logic              validQ;

    assign addr = rd_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
      dataD = regs[addr];
      pendD = pend[addr];
`ifdef RF_BYPASS_EN
      // A same-edge issue to the written register re-arms the hazard.
      if (wrLive && (addr == wr_addr)) begin
        dataD = wr_data;
        pendD = iss_en && (iss_addr == wr_addr);
      end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dataQ  <= '0;
        pendQ  <= 1'b0;
        validQ <= 1'b0;
      end else begin
        validQ <= rd_en[g];
        if (rd_en[g]) begin
          dataQ <= dataD;
          pendQ <= pendD;
        end
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = dataQ;
    assign rd_pending[g]               = pendQ;
    assign rd_valid[g]                 = validQ;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed plan steps plus randomized traffic against an array-based model.
module tb_regfile_mp_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [NR-1:0]    rd_en = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic [NR-1:0]    rd_pending;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             iss_en = 1'b0;
  logic [AW-1:0]    iss_addr = '0;
  logic             busy_any;

  logic [3:0]  sRdEn = '0;
  logic [11:0] sRdAddr = '0;
  logic [63:0] sRdData;
  logic [3:0]  sRdValid;
  logic [3:0]  sRdPending;
  logic        sWrEn = 1'b0;
  logic [2:0]  sWrAddr = '0;
  logic [15:0] sWrData = '0;
  logic        sIssEn = 1'b0;
  logic [2:0]  sIssAddr = '0;
  logic        sBusy;

  int nVec = 0;
  int nMis = 0;

  logic [DW-1:0] mMem [DEPTH];
  logic          mPend [DEPTH];
  logic [DW-1:0] eData [NR];
  logic          ePend [NR];
  logic          eValid [NR];
  logic          eBusy;

  always #5 clk = ~clk;

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_pending(rd_pending),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_any(busy_any)
  );

  regfile_mp_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dutSmall (
    .clk(clk), .reset(reset),
    .rd_en(sRdEn), .rd_addr(sRdAddr), .rd_data(sRdData),
    .rd_valid(sRdValid), .rd_pending(sRdPending),
    .wr_en(sWrEn), .wr_addr(sWrAddr), .wr_data(sWrData),
    .iss_en(sIssEn), .iss_addr(sIssAddr), .busy_any(sBusy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int a = 0; a < DEPTH; a++) begin
      mMem[a]  = '0;
      mPend[a] = 1'b0;
    end
    for (int p = 0; p < NR; p++) begin
      eData[p]  = '0;
      ePend[p]  = 1'b0;
      eValid[p] = 1'b0;
    end
    eBusy = 1'b0;
  endtask

  // Predict from the model, advance one edge, then compare every output.
  task automatic cycle();
    logic [AW-1:0] a;
    logic          byp;
    for (int p = 0; p < NR; p++) begin
      eValid[p] = rd_en[p];
      if (rd_en[p]) begin
        a   = rd_addr[p*AW +: AW];
        byp = 1'b0;
`ifdef RF_BYPASS_EN
        byp = wr_en && (wr_addr != 0) && (a == wr_addr);
`endif
        if (byp) begin
          eData[p] = wr_data;
          ePend[p] = iss_en && (iss_addr == wr_addr);
        end else begin
          eData[p] = (a == 0) ? '0 : mMem[a];
          ePend[p] = (a == 0) ? 1'b0 : mPend[a];
        end
      end
    end
    if (wr_en && wr_addr != 0) mMem[wr_addr] = wr_data;
    if (wr_en) mPend[wr_addr] = 1'b0;
    if (iss_en && iss_addr != 0) mPend[iss_addr] = 1'b1;
    eBusy = 1'b0;
    for (int k = 0; k < DEPTH; k++) if (mPend[k]) eBusy = 1'b1;
    @(posedge clk);
    #1;
    for (int p = 0; p < NR; p++) begin
      check($sformatf("rd_data%0d", p), 64'(rd_data[p*DW +: DW]), 64'(eData[p]));
      check($sformatf("rd_pending%0d", p), 64'(rd_pending[p]), 64'(ePend[p]));
      check($sformatf("rd_valid%0d", p), 64'(rd_valid[p]), 64'(eValid[p]));
    end
    check("busy_any", 64'(busy_any), 64'(eBusy));
  endtask

  task automatic idle();
    rd_en = '0; wr_en = 1'b0; iss_en = 1'b0;
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Build some state, then assert reset mid-cycle and observe the asynchronous clear.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hAAAA_5555; iss_en = 1'b1; iss_addr = 5'd4;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    cycle();
    idle();
    rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
    cycle();
    idle();
    #3;
    reset = 1'b0;
    #1;
    modelReset();
    check("async_rst_data", 64'(rd_data), 64'd0);
    check("async_rst_valid", 64'(rd_valid), 64'd0);
    check("async_rst_busy", 64'(busy_any), 64'd0);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset then read R5/R31
    rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
    cycle();
    check("rst_read_pend", 64'(rd_pending), 64'd0);

    // Write then read R7
    idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    cycle();
    idle();
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
    cycle();
    check("r7_data", 64'(rd_data[DW +: DW]), 64'hDEAD_BEEF);
    idle();
    cycle();

    // R0 protection
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; iss_en = 1'b1; iss_addr = 5'd0;
    cycle();
    idle();
    rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    cycle();

    // Scoreboard sequence on R3
    idle();
    iss_en = 1'b1; iss_addr = 5'd3;
    cycle();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    cycle();
    check("r3_pend", 64'(rd_pending[0]), 64'd1);
    iss_en = 1'b1; iss_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    cycle();
    check("r3_coll_busy", 64'(busy_any), 64'd1);
    idle();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h66;
    cycle();
    check("r3_clear_busy", 64'(busy_any), 64'd0);
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    cycle();

    // Same-edge read/write of R9 with an outstanding issue
    idle();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
    cycle();
    idle();
    iss_en = 1'b1; iss_addr = 5'd9;
    cycle();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9}; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h22;
    cycle();
`ifdef RF_BYPASS_EN
    check("r9_byp_data", 64'(rd_data[0 +: DW]), 64'h22);
    check("r9_byp_pend", 64'(rd_pending[0]), 64'd0);
`else
    check("r9_old_data", 64'(rd_data[0 +: DW]), 64'h11);
    check("r9_old_pend", 64'(rd_pending[0]), 64'd1);
`endif

    // Narrow four-port instance: all ports read R6 together
    idle();
    sWrEn = 1'b1; sWrAddr = 3'd6; sWrData = 16'h1234;
    cycle();
    sWrEn = 1'b0;
    sRdEn = 4'hF; sRdAddr = {4{3'd6}};
    cycle();
    sRdEn = 4'h0;
    for (int p = 0; p < 4; p++) begin
      check($sformatf("small_data%0d", p), 64'(sRdData[p*16 +: 16]), 64'h1234);
    end
    check("small_valid", 64'(sRdValid), 64'hF);
    cycle();
    check("small_valid_drop", 64'(sRdValid), 64'h0);

    // Randomized traffic; narrow address range forces collisions
    for (int n = 0; n < 400; n++) begin
      rd_en    = NR'($urandom);
      rd_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      if (n % 4 == 0) rd_addr = NR*AW'($urandom);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = AW'($urandom_range(0, 7));
      cycle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor of the single-cycle register file, for the pipelined core.
- NUM_RD registered read ports and one write port.
- R0 hardwired to zero.
- Per-register scoreboard: pending bits are set on issue and cleared on writeback; each read port reports the hazard.
- Sits between decode (issue/read) and writeback. Immediate generation stays in decode.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- rd_en  in  NUM_RD  per-port read strobe
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data; port i occupies bits [i*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  high for exactly one cycle after an accepted read
- rd_pending  out  NUM_RD  registered: the addressed register had a write outstanding at read time
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  issue strobe; marks iss_addr pending
- iss_addr  in  ADDR_W  issued destination register
- busy_any  out  1  OR of all pending bits (drain/flush indicator)

Behaviour:
- Reset (reset low, asynchronous), applied immediately regardless of clk:
  - all registers = 0
  - all pending bits = 0
  - rd_data = 0, rd_valid = 0, rd_pending = 0, busy_any = 0
- Reset assertion mid-operation discards all in-flight reads and pending state.
- Release is synchronous to the next rising edge.
- Write: on a rising edge with wr_en=1 and wr_addr!=0, R[wr_addr] <= wr_data.
  - A write to R0 is ignored.
  - R0 always reads 0.
- Read latency is 1 cycle. On a rising edge with rd_en[i]=1:
  - rd_data[i] <= R[rd_addr[i]]
  - rd_pending[i] <= pend[rd_addr[i]]
  - rd_valid[i] <= 1
- With rd_en[i]=0: rd_data[i] and rd_pending[i] hold their values; rd_valid[i] <= 0.
- Ports are fully independent. Several ports may read the same address in the same cycle and receive identical results.
- Scoreboard (pend[0..depth-1]), per rising edge and address a:
  - set if iss_en && iss_addr==a
  - else clear if wr_en && wr_addr==a
  - else hold
- Simultaneous issue and writeback to the same address: the set wins and the bit stays 1 (new producer outstanding).
- Issue to an already-pending register (WAW): the bit stays 1. No counting; the first writeback clears it.
- Writeback to a non-pending register: data is written and the bit stays 0. No error.
- pend[0] is forced to 0; issue to R0 is ignored.
- busy_any is registered: it equals the OR of the pending bits after each edge.
- Read/write same address, same edge, without the bypass feature: rd_data returns the old value and rd_pending returns the pre-update pending bit.

Optional Feature:
- Macro: RF_BYPASS_EN
- Defined: a read with rd_addr[i]==wr_addr, wr_en=1 and wr_addr!=0 in the same edge returns rd_data[i]=wr_data.
  - rd_pending[i] = 0, unless the same edge also has iss_en with iss_addr==wr_addr, in which case rd_pending[i] = 1.
  - Decode then needs no extra stall cycle after writeback.
- Undefined: no forwarding. The old value and the raw pending bit are returned as specified above.

Test Plan:
- Reset then read: assert reset low mid-cycle, then release; read ports 0/1 at R5/R31 -> rd_data=0,0; rd_pending=0,0; busy_any=0.
- Write then read: write R7=0xDEADBEEF; next cycle read port 1 at R7 -> rd_data[1]=0xDEADBEEF one cycle later, rd_valid[1] pulses for one cycle.
- R0 protection: write R0=0xFFFFFFFF and issue R0 -> a read of R0 returns 0, rd_pending=0, busy_any=0.
- Scoreboard sequence: issue R3 -> busy_any=1, a read of R3 gives rd_pending=1.
  - Same-edge issue R3 + writeback R3 -> the bit stays 1.
  - Writeback R3 alone -> the bit clears, busy_any=0.
- Same-edge read/write R9 (old value 0x11, new value 0x22):
  - without RF_BYPASS_EN -> rd_data=0x11, rd_pending=1 (R9 was issued before)
  - with RF_BYPASS_EN -> rd_data=0x22, rd_pending=0
- Parameter sweep: DATA_W=16, ADDR_W=3, NUM_RD=4; all four ports read R6 in the same cycle after write R6=0x1234 -> all four return 0x1234.
